// File: rtl/voice_scheduler.sv
// Round-robin dispatcher that hands one held note at a time to a free note_player.
// Loads still in flight are tracked so that consecutive notes never land on the same player.
module voice_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  song_done,
    input  logic                  beat,
    input  logic                  new_note,
    input  logic [NOTE_W-1:0]     note_in,
    input  logic [DUR_W-1:0]      duration_in,
    output logic                  note_ready,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] load_voice,
    output logic [NOTE_W-1:0]     note_out,
    output logic [DUR_W-1:0]      duration_out,
    output logic                  player_available,
    output logic [7:0]            drop_count
);

    localparam int PW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [PW1-1:0] NV_L       = PW1'(NUM_VOICES);
    localparam logic [7:0]     MAX_WAIT_L = 8'(MAX_WAIT);

    typedef enum logic [0:0] {S_EMPTY = 1'b0, S_HELD = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NOTE_W-1:0]     r_note_hold;
    logic [DUR_W-1:0]      r_dur_hold;
    logic [7:0]            r_wait;
    logic [PW-1:0]         r_rr_ptr;
    logic [NUM_VOICES-1:0] r_claimed;
    logic [NUM_VOICES-1:0] r_load_voice;
    logic [NOTE_W-1:0]     r_note_out;
    logic [DUR_W-1:0]      r_dur_out;
    logic [7:0]            r_drop_count;
    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_pick;
    logic [PW1-1:0]        w_idx;
    logic [PW1-1:0]        w_rr_sum;
    logic [PW-1:0]         w_sel;
    logic [PW-1:0]         w_rr_next;
    logic                  w_found;
    logic                  w_accept;
    logic                  w_flush;
    logic                  w_dispatch;
    logic                  w_beat_inc;
    logic                  w_timeout;
    logic                  w_note_ready;

    assign w_free           = voice_done & ~r_claimed;
    assign player_available = |w_free;
    assign w_accept         = (r_state == S_EMPTY) & new_note;
    assign w_flush          = (r_state == S_HELD) & song_done;
    assign w_dispatch       = (r_state == S_HELD) & ~song_done & play_enable & w_found;
    // A beat that coincides with a dispatch is not counted toward the timeout
    assign w_beat_inc       = (r_state == S_HELD) & ~song_done & ~w_dispatch & beat;
    assign w_timeout        = w_beat_inc & ((r_wait + 8'd1) == MAX_WAIT_L);

    // First free voice at or above rr_ptr, wrapping modulo NUM_VOICES
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + PW1'(k);
            if (w_idx >= NV_L) begin
                w_idx = w_idx - NV_L;
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && w_free[w_idx[PW-1:0]]) begin
                w_found                = 1'b1;
                w_sel                  = w_idx[PW-1:0];
                w_pick[w_idx[PW-1:0]]  = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Round-robin pointer advance: one past the chosen voice
    always_comb begin
        w_rr_sum = {1'b0, w_sel} + PW1'(1);
        if (w_rr_sum >= NV_L) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_rr_sum[PW-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; in HELD a flush, dispatch or timeout all empty the hold register
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: w_next_state = w_accept ? S_HELD : S_EMPTY;
            S_HELD:  w_next_state = (w_flush | w_dispatch | w_timeout) ? S_EMPTY : S_HELD;
            default: w_next_state = S_EMPTY;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_note_ready = 1'b1;
        case (r_state)
            S_EMPTY: w_note_ready = 1'b1;
            S_HELD:  w_note_ready = 1'b0;
            default: w_note_ready = 1'b1;
        endcase
    end

    assign note_ready = w_note_ready;

    // Hold register and wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_note_hold <= '0;
            r_dur_hold  <= '0;
            r_wait      <= 8'd0;
        end else if (w_accept) begin
            r_note_hold <= note_in;
            r_dur_hold  <= duration_in;
            r_wait      <= 8'd0;
        end else if (w_beat_inc) begin
            r_wait      <= r_wait + 8'd1;
        end else begin
            r_wait      <= r_wait;
        end
    end

    // Dispatch datapath: load pulse, presented note, pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load_voice <= '0;
            r_note_out   <= '0;
            r_dur_out    <= '0;
            r_rr_ptr     <= '0;
        end else if (w_dispatch) begin
            r_load_voice <= w_pick;
            r_note_out   <= r_note_hold;
            r_dur_out    <= r_dur_hold;
            r_rr_ptr     <= w_rr_next;
        end else begin
            r_load_voice <= '0;
        end
    end

    // A claim lasts until the player drops done after the load cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_claimed <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (w_dispatch && w_pick[i]) begin
                    r_claimed[i] <= 1'b1;
                end else if (r_claimed[i] && !r_load_voice[i] && !voice_done[i]) begin
                    r_claimed[i] <= 1'b0;
                end else begin
                    r_claimed[i] <= r_claimed[i];
                end
            end
        end
    end

    // Saturating dropped-note counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_count <= 8'd0;
        end else if (w_timeout && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end else begin
            r_drop_count <= r_drop_count;
        end
    end

    assign load_voice   = r_load_voice;
    assign note_out     = r_note_out;
    assign duration_out = r_dur_out;
    assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed scenarios plus a randomized run against a behavioural scheduler model.
module tb_voice_scheduler;

    localparam int NV = 3;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          play_enable;
    logic          song_done;
    logic          beat;
    logic          new_note;
    logic [5:0]    note_in;
    logic [5:0]    duration_in;
    logic          note_ready;
    logic [NV-1:0] voice_done;
    logic [NV-1:0] load_voice;
    logic [5:0]    note_out;
    logic [5:0]    duration_out;
    logic          player_available;
    logic [7:0]    drop_count;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit            m_held;
    logic [5:0]    m_note, m_dur, m_note_out, m_dur_out;
    int            m_wait, m_rr, m_drops;
    bit            m_claimed [NV];
    logic [NV-1:0] m_load;

    voice_scheduler #(.NUM_VOICES(NV), .NOTE_W(6), .DUR_W(6), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .play_enable(play_enable), .song_done(song_done),
        .beat(beat), .new_note(new_note), .note_in(note_in), .duration_in(duration_in),
        .note_ready(note_ready), .voice_done(voice_done), .load_voice(load_voice),
        .note_out(note_out), .duration_out(duration_out),
        .player_available(player_available), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; play_enable = 1'b0; song_done = 1'b0; beat = 1'b0;
        new_note = 1'b0; note_in = 6'd0; duration_in = 6'd0; voice_done = 3'b111;
        cyc();
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_held = 1'b0; m_note = 6'd0; m_dur = 6'd0; m_note_out = 6'd0; m_dur_out = 6'd0;
        m_wait = 0; m_rr = 0; m_drops = 0; m_load = '0;
        for (int i = 0; i < NV; i++) m_claimed[i] = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit nc [NV];
        logic [NV-1:0] nload;
        int v;
        nload = '0;
        v = -1;
        for (int i = 0; i < NV; i++) begin
            nc[i] = m_claimed[i];
            if (m_claimed[i] && !m_load[i] && !voice_done[i]) nc[i] = 1'b0;
        end
        if (!m_held) begin
            if (new_note) begin
                m_held = 1'b1; m_note = note_in; m_dur = duration_in; m_wait = 0;
            end
        end else if (song_done) begin
            m_held = 1'b0;
        end else begin
            if (play_enable)
                for (int k = 0; k < NV; k++) begin
                    int j;
                    j = (m_rr + k) % NV;
                    if (v < 0 && voice_done[j] && !m_claimed[j]) v = j;
                end
            if (v >= 0) begin
                nload[v] = 1'b1; nc[v] = 1'b1;
                m_note_out = m_note; m_dur_out = m_dur;
                m_rr = (v + 1) % NV; m_held = 1'b0;
            end else if (beat) begin
                m_wait++;
                if (m_wait == MW) begin
                    m_held = 1'b0;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        m_claimed = nc;
        m_load = nload;
    endtask

    task automatic test_reset();
        reset = 1'b0; voice_done = 3'b111; play_enable = 1'b0; song_done = 1'b0;
        beat = 1'b0; new_note = 1'b0; note_in = 6'd0; duration_in = 6'd0;
        #1;
        checks++;
        if (load_voice !== 3'b000 || note_out !== 6'd0 || duration_out !== 6'd0) begin
            failures++;
            $display("FAIL reset_outs: load=%b note=%0d dur=%0d, want 000/0/0", load_voice, note_out, duration_out);
        end
        checks++;
        if (note_ready !== 1'b1 || drop_count !== 8'd0 || player_available !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: ready=%b drops=%0d avail=%b, want 1/0/1", note_ready, drop_count, player_available);
        end
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_basic_latency();
        do_reset();
        play_enable = 1'b1;
        new_note = 1'b1; note_in = 6'd20; duration_in = 6'd12;
        cyc();
        new_note = 1'b0;
        checks++;
        if (note_ready !== 1'b0 || load_voice !== 3'b000) begin
            failures++;
            $display("FAIL basic_held: ready=%b load=%b, want 0/000", note_ready, load_voice);
        end
        cyc();
        checks++;
        if (load_voice !== 3'b001 || note_out !== 6'd20 || duration_out !== 6'd12 || note_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_pulse: load=%b note=%0d dur=%0d ready=%b, want 001/20/12/1",
                     load_voice, note_out, duration_out, note_ready);
        end
        cyc();
        checks++;
        if (load_voice !== 3'b000 || note_out !== 6'd20 || duration_out !== 6'd12) begin
            failures++;
            $display("FAIL basic_hold_out: load=%b note=%0d dur=%0d, want 000/20/12", load_voice, note_out, duration_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_l;
        do_reset();
        play_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            new_note = 1'b1; note_in = 6'(10 + k); duration_in = 6'(k + 1);
            cyc();
            new_note = 1'b0;
            cyc();
            exp_l = 3'b001 << k;
            checks++;
            if (load_voice !== exp_l || note_out !== 6'(10 + k)) begin
                failures++;
                $display("FAIL b2b_pulse%0d: load=%b note=%0d, want %b/%0d", k, load_voice, note_out, exp_l, 10 + k);
            end
        end
        new_note = 1'b1; note_in = 6'd13; duration_in = 6'd7;
        cyc();
        new_note = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (load_voice !== 3'b000 || player_available !== 1'b0 || note_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_wait%0d: load=%b avail=%b ready=%b, want 000/0/0", k, load_voice, player_available, note_ready);
            end
        end
        voice_done = 3'b001;
        cyc();
        voice_done = 3'b111;
        cyc();
        checks++;
        if (load_voice !== 3'b010 || note_out !== 6'd13 || duration_out !== 6'd7) begin
            failures++;
            $display("FAIL b2b_fourth: load=%b note=%0d dur=%0d, want 010/13/7", load_voice, note_out, duration_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        play_enable = 1'b1; voice_done = 3'b000;
        new_note = 1'b1; note_in = 6'd30; duration_in = 6'd3;
        cyc();
        new_note = 1'b0;
        for (int b = 1; b <= MW; b++) begin
            beat = 1'b1;
            cyc();
            beat = 1'b0;
            checks++;
            if (load_voice !== 3'b000 || note_ready !== (b == MW) || drop_count !== 8'((b == MW) ? 1 : 0)) begin
                failures++;
                $display("FAIL timeout_beat%0d: load=%b ready=%b drops=%0d, want 000/%0d/%0d",
                         b, load_voice, note_ready, drop_count, (b == MW), (b == MW) ? 1 : 0);
            end
            cyc();
        end
    endtask

    task automatic test_play_enable();
        do_reset();
        play_enable = 1'b0; voice_done = 3'b111;
        new_note = 1'b1; note_in = 6'd40; duration_in = 6'd9;
        cyc();
        new_note = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (load_voice !== 3'b000 || note_ready !== 1'b0) begin
                failures++;
                $display("FAIL pe_frozen%0d: load=%b ready=%b, want 000/0", k, load_voice, note_ready);
            end
        end
        play_enable = 1'b1;
        cyc();
        checks++;
        if (load_voice !== 3'b001 || note_out !== 6'd40 || note_ready !== 1'b1) begin
            failures++;
            $display("FAIL pe_release: load=%b note=%0d ready=%b, want 001/40/1", load_voice, note_out, note_ready);
        end
    endtask

    task automatic test_song_done();
        do_reset();
        play_enable = 1'b1; voice_done = 3'b000;
        new_note = 1'b1; note_in = 6'd50; duration_in = 6'd5;
        cyc();
        new_note = 1'b0;
        cyc();
        song_done = 1'b1; voice_done = 3'b111;
        cyc();
        song_done = 1'b0;
        checks++;
        if (load_voice !== 3'b000 || note_ready !== 1'b1 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL song_done_flush: load=%b ready=%b drops=%0d, want 000/1/0", load_voice, note_ready, drop_count);
        end
        cyc();
        checks++;
        if (load_voice !== 3'b000) begin
            failures++;
            $display("FAIL song_done_after: load=%b, want 000", load_voice);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        play_enable = 1'b1; voice_done = 3'b111;
        new_note = 1'b1; note_in = 6'd60; duration_in = 6'd1;
        cyc();
        new_note = 1'b0;
        cyc();
        voice_done = 3'b001;
        new_note = 1'b1; note_in = 6'd61;
        cyc();
        new_note = 1'b0;
        checks++;
        if (player_available !== 1'b0 || note_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: avail=%b ready=%b, want 0/0", player_available, note_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (load_voice !== 3'b000 || note_ready !== 1'b1 || player_available !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_now: load=%b ready=%b avail=%b, want 000/1/1", load_voice, note_ready, player_available);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc();
        checks++;
        if (load_voice !== 3'b000 || note_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_after: load=%b ready=%b, want 000/1", load_voice, note_ready);
        end
    endtask

    task automatic test_random();
        bit exp_avail;
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            play_enable = ($urandom_range(0, 3) != 0);
            song_done   = ($urandom_range(0, 19) == 0);
            beat        = ($urandom_range(0, 2) == 0);
            new_note    = $urandom_range(0, 1);
            note_in     = 6'($urandom);
            duration_in = 6'($urandom);
            for (int i = 0; i < NV; i++) voice_done[i] = ($urandom_range(0, 2) != 0);
            model_step();
            cyc();
            exp_avail = 1'b0;
            for (int i = 0; i < NV; i++) if (voice_done[i] && !m_claimed[i]) exp_avail = 1'b1;
            checks++;
            if (load_voice !== m_load || note_out !== m_note_out || duration_out !== m_dur_out) begin
                failures++;
                $display("FAIL rand_dispatch@%0d: load=%b note=%0d dur=%0d, want %b/%0d/%0d",
                         n, load_voice, note_out, duration_out, m_load, m_note_out, m_dur_out);
            end
            checks++;
            if (note_ready !== !m_held || drop_count !== 8'(m_drops) || player_available !== exp_avail) begin
                failures++;
                $display("FAIL rand_status@%0d: ready=%b drops=%0d avail=%b, want %b/%0d/%b",
                         n, note_ready, drop_count, player_available, !m_held, m_drops, exp_avail);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_back_to_back();
        test_timeout();
        test_play_enable();
        test_song_done();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Round-robin voice scheduler between the song reader and a bank of `note_player` instances. Accepts one note at a time through a ready/valid handshake, holds it until a player is free and playback is enabled, then issues a one-cycle load pulse with the note and duration to that player. It tracks in-flight loads so that back-to-back notes never land on the same player. Notes that wait too long are dropped and counted.

## Interface
- `NUM_VOICES`, default 3: number of note players driven.
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration width.
- `MAX_WAIT`, default 8: beats a held note may wait for a free voice before it is dropped; range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `play_enable`  in  1  dispatch allowed when high.
- `song_done`  in  1  flushes the held note.
- `beat`  in  1  one-cycle 1/48 s tick.
- `new_note`  in  1  request valid.
- `note_in`  in  `NOTE_W`  note code.
- `duration_in`  in  `DUR_W`  duration.
- `note_ready`  out  1  hold register empty; request accepted when `new_note & note_ready`.
- `voice_done`  in  `NUM_VOICES`  `done_with_note` from each player.
- `load_voice`  out  `NUM_VOICES`  one-hot, one-cycle load pulse.
- `note_out`  out  `NOTE_W`  note presented with `load_voice`.
- `duration_out`  out  `DUR_W`  duration presented with `load_voice`.
- `player_available`  out  1  at least one voice is free.
- `drop_count`  out  8  saturating count of dropped notes.

## Operation
- `claimed[i]` is set on the cycle `load_voice[i]` is high. It clears on the first later cycle where `voice_done[i]` is sampled low, meaning the player took the note.
- `free[i] = voice_done[i] & ~claimed[i]`.
- `player_available = |free`.
- States:
  - EMPTY: `note_ready=1`. On `new_note`, capture `note_in`/`duration_in` and clear the wait counter. Go to HELD.
  - HELD: `note_ready=0`.
    - If `song_done`: discard the note, go to EMPTY. No drop count.
    - Else if `play_enable & |free`: pick the first free voice scanning upward from `rr_ptr`, wrapping at `NUM_VOICES-1`. Register a `load_voice` pulse for it. Set `rr_ptr` to the chosen voice +1 (mod N). Go to EMPTY.
    - Else, on each `beat`, increment the wait counter. When it reaches `MAX_WAIT`, drop the note, increment `drop_count` (saturating at 255), and go to EMPTY.
- `new_note` while `note_ready=0` is ignored; no state change.
- Priority in HELD: `song_done` > dispatch > timeout.
- `play_enable` low freezes dispatch. The wait counter still runs on `beat`.
- `note_out`/`duration_out` hold their last dispatched values between pulses.

## Timing
- Reset (asynchronous assert, release on a clock edge): state EMPTY, `rr_ptr=0`, `claimed=0`, wait counter 0. Outputs: `load_voice=0`, `note_out=0`, `duration_out=0`, `drop_count=0`, `note_ready=1`. `player_available` follows `voice_done` (all claims cleared).
- Reset asserted mid-operation discards the held note and any pending load pulse immediately. `drop_count` is cleared.
- Latency: `new_note` accepted at edge t. `load_voice`/`note_out`/`duration_out` are valid during cycle t+2 if a voice is free at t+1. `note_ready` returns high in cycle t+2.
- Back-to-back: a second `new_note` accepted at t+2 sees `claimed` set for the first voice. It dispatches to a different voice in cycle t+4, even though `voice_done` is still high.
- `load_voice` is never wider than one cycle and never has more than one bit set.
- A `beat` coinciding with dispatch does not count toward timeout.

## Test plan
- Reset, all `voice_done=3'b111`, `play_enable=1`, note 6'd20/dur 6'd12 at t → `load_voice=3'b001`, `note_out=20`, `duration_out=12` in cycle t+2; `note_ready` high again at t+2.
- Three notes 10, 11, 12 back-to-back with `voice_done` held at 3'b111 → pulses 001, 010, 100 in order. A fourth note 13 waits until a voice drops `done` and returns high. Its voice follows round-robin from `rr_ptr=0`.
- `voice_done=3'b000`, note held, `MAX_WAIT=8`, 8 beats → note dropped, `drop_count=1`, `note_ready=1`, no `load_voice`.
- `play_enable=0` with a free voice → no pulse for any number of cycles below timeout. Raising `play_enable` dispatches on the next cycle.
- Held note, then `song_done` pulse together with `voice_done` going free → no `load_voice`, `drop_count` unchanged, `note_ready=1`.
- `reset` asserted low in the cycle after acceptance → `load_voice` stays 0, `note_ready=1` immediately, `claimed` cleared.
